// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared constants and helpers for the DVI TMDS encoder.
//   SYM_W         : TMDS symbol width (10 bits)
//   CTRL_00.._11  : control-period symbols indexed by {c1,c0}
//   popcount8     : number of ones in a byte
//   popcount_qm   : number of ones in the data part (bits 7:0) of q_m
//   ctrl_symbol   : maps {c1,c0} to the control symbol
// -----------------------------------------------------------------------------
package tmds_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] CTRL_00 = 10'h354;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'h0AB;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'h154;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'h2AB;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // q_m[8] only flags the chain type; disparity is counted on bits 7:0
   function automatic logic [3:0] popcount_qm(input logic [8:0] qm);
      return popcount8(qm[7:0]);
   endfunction

   function automatic logic [SYM_W-1:0] ctrl_symbol(input logic c1, input logic c0);
      logic [SYM_W-1:0] s;
      case ({c1, c0})
         2'b00:   s = CTRL_00;
         2'b01:   s = CTRL_01;
         2'b10:   s = CTRL_10;
         default: s = CTRL_11;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_encoder
// One TMDS channel: stage 1 transition minimisation (q_m) and stage 2 DC
// balancing with a running disparity counter. Two register stages.
// Ports:
//   pixel_clk  in   video clock
//   reset      in   synchronous, active-high
//   d[7:0]     in   pixel component (ignored while de=0)
//   de         in   1 = video period, 0 = control period
//   c1, c0     in   control bits sent during the control period
//   symbol     out  10-bit TMDS symbol (inverted when INVERT=1)
// Parameters:
//   INVERT     board polarity swap, applied as the last step before the register
// -----------------------------------------------------------------------------
module tmds_channel_encoder
   import tmds_pkg::*;
#(
   parameter logic INVERT = 1'b0
) (
   input  logic             pixel_clk,
   input  logic             reset,
   input  logic [7:0]       d,
   input  logic             de,
   input  logic             c1,
   input  logic             c0,
   output logic [SYM_W-1:0] symbol
);

   localparam logic [SYM_W-1:0] INV_MASK = {SYM_W{INVERT}};

   // stage 1
   logic [7:0] d_gated;
   logic [3:0] n1_d;
   logic       use_xnor;
   logic [8:0] qm_next;

   logic [8:0] qm_r;
   logic       de_r;
   logic       c1_r;
   logic       c0_r;

   // stage 2
   logic signed [4:0]       cnt_r;
   logic [3:0]              n1_q;
   logic signed [5:0]       bal;
   logic signed [5:0]       cnt_ext;
   logic signed [5:0]       cnt_next;
   logic [SYM_W-1:0]        sym_next;

   // Gating by de keeps undefined pixel data out of the pipeline during blanking
   always_comb begin
      d_gated  = de ? d : 8'h00;
      n1_d     = popcount8(d_gated);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d_gated[0]);
      qm_next    = '0;
      qm_next[0] = d_gated[0];
      for (int i = 1; i < 8; i++) begin
         qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d_gated[i]) : (qm_next[i-1] ^ d_gated[i]);
      end
      qm_next[8] = ~use_xnor;
   end

   // bal = N1 - N0 of q_m[7:0] = 2*N1 - 8; 6-bit math so intermediates never wrap
   always_comb begin
      n1_q     = popcount_qm(qm_r);
      bal      = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      cnt_ext  = {cnt_r[4], cnt_r};
      sym_next = CTRL_00;
      cnt_next = '0;
      if (!de_r) begin
         sym_next = ctrl_symbol(c1_r, c0_r);
         cnt_next = '0;
      end else if ((cnt_r == 5'sd0) || (n1_q == 4'd4)) begin
         sym_next = {~qm_r[8], qm_r[8], (qm_r[8] ? qm_r[7:0] : ~qm_r[7:0])};
         cnt_next = qm_r[8] ? (cnt_ext + bal) : (cnt_ext - bal);
      end else if (((cnt_r > 5'sd0) && (n1_q > 4'd4)) || ((cnt_r < 5'sd0) && (n1_q < 4'd4))) begin
         sym_next = {1'b1, qm_r[8], ~qm_r[7:0]};
         cnt_next = cnt_ext + (qm_r[8] ? 6'sd2 : 6'sd0) - bal;
      end else begin
         sym_next = {1'b0, qm_r[8], qm_r[7:0]};
         cnt_next = cnt_ext - (qm_r[8] ? 6'sd0 : 6'sd2) + bal;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         qm_r   <= '0;
         de_r   <= 1'b0;
         c1_r   <= 1'b0;
         c0_r   <= 1'b0;
         cnt_r  <= '0;
         symbol <= CTRL_00 ^ INV_MASK;
      end else begin
         qm_r   <= qm_next;
         de_r   <= de;
         c1_r   <= c1;
         c0_r   <= c0;
         cnt_r  <= cnt_next[4:0];
         symbol <= sym_next ^ INV_MASK;
      end
   end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// -----------------------------------------------------------------------------
// dvi_tmds_encoder
// DVI 1.0 TMDS encoder: RGB888 + data_enable + hSync/vSync in, three 10-bit
// TMDS symbols out every pixel_clk. Blue carries {vSync,hSync} as {c1,c0}.
// Latency is 2 + EXTRA_STAGES cycles on every channel.
// Ports:
//   pixel_clk, reset              clock, synchronous active-high reset
//   data_red/green/blue[7:0]      pixel components, valid when data_enable=1
//   data_enable                   1 = video period, 0 = control period
//   hSync, vSync                  sync bits (polarity already adjusted)
//   test_pattern                  colour-bar select (TMDS_TEST_PATTERN_EN only)
//   tmds_red/green/blue[9:0]      channel 2/1/0 symbols, bit 0 sent first
// Parameters:
//   CHANNEL_INVERT {red,green,blue} per-channel output inversion
//   EXTRA_STAGES   0..2 extra output register stages
// Build option:
//   TMDS_TEST_PATTERN_EN  adds test_pattern and an 8-bar colour generator
// -----------------------------------------------------------------------------
module dvi_tmds_encoder
   import tmds_pkg::*;
#(
   parameter logic [2:0] CHANNEL_INVERT = 3'b000,
   parameter int         EXTRA_STAGES   = 0
) (
   input  logic             pixel_clk,
   input  logic             reset,
   input  logic [7:0]       data_red,
   input  logic [7:0]       data_green,
   input  logic [7:0]       data_blue,
   input  logic             data_enable,
   input  logic             hSync,
   input  logic             vSync,
`ifdef TMDS_TEST_PATTERN_EN
   input  logic             test_pattern,
`endif
   output logic [SYM_W-1:0] tmds_red,
   output logic [SYM_W-1:0] tmds_green,
   output logic [SYM_W-1:0] tmds_blue
);

   localparam logic [3*SYM_W-1:0] RST_WORD = {
      CTRL_00 ^ {SYM_W{CHANNEL_INVERT[2]}},
      CTRL_00 ^ {SYM_W{CHANNEL_INVERT[1]}},
      CTRL_00 ^ {SYM_W{CHANNEL_INVERT[0]}}
   };

   logic [7:0]         enc_red;
   logic [7:0]         enc_green;
   logic [7:0]         enc_blue;
   logic [SYM_W-1:0]   sym_red;
   logic [SYM_W-1:0]   sym_green;
   logic [SYM_W-1:0]   sym_blue;
   logic [3*SYM_W-1:0] sym_all;
   logic [3*SYM_W-1:0] out_all;

`ifdef TMDS_TEST_PATTERN_EN
   logic [11:0] pixel_x;
   logic [23:0] bar_rgb;

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         pixel_x <= '0;
      end else if (data_enable) begin
         pixel_x <= pixel_x + 12'd1;
      end else begin
         pixel_x <= '0;
      end
   end

   // 128-pixel bars: white, yellow, cyan, green, magenta, red, blue, black
   always_comb begin
      case (pixel_x[9:7])
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   assign {enc_red, enc_green, enc_blue} = test_pattern ? bar_rgb
                                                        : {data_red, data_green, data_blue};
`else
   assign enc_red   = data_red;
   assign enc_green = data_green;
   assign enc_blue  = data_blue;
`endif

   tmds_channel_encoder #(.INVERT(CHANNEL_INVERT[2])) u_ch_red (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .d         (enc_red),
      .de        (data_enable),
      .c1        (1'b0),
      .c0        (1'b0),
      .symbol    (sym_red)
   );

   tmds_channel_encoder #(.INVERT(CHANNEL_INVERT[1])) u_ch_green (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .d         (enc_green),
      .de        (data_enable),
      .c1        (1'b0),
      .c0        (1'b0),
      .symbol    (sym_green)
   );

   tmds_channel_encoder #(.INVERT(CHANNEL_INVERT[0])) u_ch_blue (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .d         (enc_blue),
      .de        (data_enable),
      .c1        (vSync),
      .c0        (hSync),
      .symbol    (sym_blue)
   );

   assign sym_all = {sym_red, sym_green, sym_blue};

   generate
      if (EXTRA_STAGES == 0) begin : g_no_extra
         assign out_all = sym_all;
      end else begin : g_extra
         logic [3*SYM_W-1:0] stg [EXTRA_STAGES];
         always_ff @(posedge pixel_clk) begin
            if (reset) begin
               for (int i = 0; i < EXTRA_STAGES; i++) begin
                  stg[i] <= RST_WORD;
               end
            end else begin
               stg[0] <= sym_all;
               for (int i = 1; i < EXTRA_STAGES; i++) begin
                  stg[i] <= stg[i-1];
               end
            end
         end
         assign out_all = stg[EXTRA_STAGES-1];
      end
   endgenerate

   assign {tmds_red, tmds_green, tmds_blue} = out_all;

endmodule
